// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId registers and the pipeline
// flush/redirect sequencing for interrupts, exceptions and ERET.
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_get,
    input  logic [4:0]  exc_code,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [5:0]  hw_int,
    input  logic        eret_m,
    input  logic        mtc0_we,
    input  logic [4:0]  c0_addr,
    input  logic [31:0] mtc0_wdata,
    output logic [31:0] mfc0_rdata,
    output logic        flush,
    output logic        busy,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic [31:0] epc
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned INT_W  = 6;
    localparam int unsigned CNT_W  = 2;

    localparam logic [XLEN-1:0] PRID_VAL = 32'h0000_4C38;
    localparam logic [XLEN-1:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [4:0]      ADDR_SR    = 5'd12;
    localparam logic [4:0]      ADDR_CAUSE = 5'd13;
    localparam logic [4:0]      ADDR_EPC   = 5'd14;
    localparam logic [4:0]      ADDR_PRID  = 5'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INT_W-1:0]    im_q, im_d;
    logic                exl_q, exl_d;
    logic                ie_q, ie_d;
    logic                bd_q, bd_d;
    logic [INT_W-1:0]    ip_q, ip_d;
    logic [CODE_W-1:0]   exc_code_q, exc_code_d;
    logic [XLEN-1:0]     epc_q, epc_d;
    logic [XLEN-1:0]     target_q, target_d;
    logic                flush_q, flush_d;
    logic                busy_q, busy_d;
    logic                redir_valid_q, redir_valid_d;

    logic                int_req;
    logic [XLEN-1:0]     epc_evt;
    logic [XLEN-1:0]     sr_rd;
    logic [XLEN-1:0]     cause_rd;

    assign int_req  = (|(hw_int & im_q)) & ie_q & ~exl_q;
    // Restart address: the branch owning a delay slot, word aligned.
    assign epc_evt  = (bd_m ? (pc_m - 32'd4) : pc_m) & ~32'h0000_0003;
    assign sr_rd    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    assign cause_rd = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};

    always_comb begin
        unique case (c0_addr)
            ADDR_SR:    mfc0_rdata = sr_rd;
            ADDR_CAUSE: mfc0_rdata = cause_rd;
            ADDR_EPC:   mfc0_rdata = epc_q;
            ADDR_PRID:  mfc0_rdata = PRID_VAL;
            default:    mfc0_rdata = '0;
        endcase
    end

    // Next-state, register update and output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        target_d   = target_q;

        if (mtc0_we && !busy_q) begin
            if (c0_addr == ADDR_SR) begin
                im_d  = mtc0_wdata[15:10];
                exl_d = mtc0_wdata[1];
                ie_d  = mtc0_wdata[0];
            end else if (c0_addr == ADDR_EPC) begin
                epc_d = mtc0_wdata;
            end
        end

        // Taken events come after mtc0 so they override EXL/EPC.
        unique case (state_q)
            IDLE: begin
                if (int_req || exc_get) begin
                    exl_d      = 1'b1;
                    bd_d       = bd_m;
                    exc_code_d = int_req ? CODE_W'(0) : exc_code;
                    epc_d      = epc_evt;
                    target_d   = EXC_VEC;
                    cnt_d      = CNT_W'(1);
                    state_d    = FLUSH;
                end else if (eret_m) begin
                    exl_d    = 1'b0;
                    target_d = epc_q;
                    cnt_d    = CNT_W'(1);
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(0)) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        flush_d       = (state_d == FLUSH);
        busy_d        = (state_d != IDLE);
        redir_valid_d = (state_d == REDIRECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            im_q          <= '0;
            exl_q         <= 1'b0;
            ie_q          <= 1'b0;
            bd_q          <= 1'b0;
            ip_q          <= '0;
            exc_code_q    <= '0;
            epc_q         <= '0;
            target_q      <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redir_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            im_q          <= im_d;
            exl_q         <= exl_d;
            ie_q          <= ie_d;
            bd_q          <= bd_d;
            ip_q          <= ip_d;
            exc_code_q    <= exc_code_d;
            epc_q         <= epc_d;
            target_q      <= target_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            redir_valid_q <= redir_valid_d;
        end
    end

    assign flush       = flush_q;
    assign busy        = busy_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = target_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_get;
    logic [4:0]  exc_code;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        mtc0_we;
    logic [4:0]  c0_addr;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic        flush;
    logic        busy;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic [31:0] epc;

    int n_vec = 0;
    int n_err = 0;

    exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .exc_get     (exc_get),
        .exc_code    (exc_code),
        .pc_m        (pc_m),
        .bd_m        (bd_m),
        .hw_int      (hw_int),
        .eret_m      (eret_m),
        .mtc0_we     (mtc0_we),
        .c0_addr     (c0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .mfc0_rdata  (mfc0_rdata),
        .flush       (flush),
        .busy        (busy),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_ready (redir_ready),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        c0_addr = addr;
        #1;
        chk(tag, mfc0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we    = 1'b1;
        c0_addr    = addr;
        mtc0_wdata = data;
        tick();
        mtc0_we    = 1'b0;
    endtask

    // From the first FLUSH cycle: one more flush cycle, then accept the redirect.
    task automatic finish_seq(input string tag);
        tick();
        tick();
        chk({tag, "_rv"}, 32'(redir_valid), 32'd1);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; exc_get = 1'b0; exc_code = '0; pc_m = '0; bd_m = 1'b0;
        hw_int = '0; eret_m = 1'b0; mtc0_we = 1'b0; c0_addr = '0;
        mtc0_wdata = '0; redir_ready = 1'b0;

        tick();
        tick();
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(redir_valid), 32'd0);
        chk("rst_rpc", redir_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        reset = 1'b0;
        tick();
        rd("prid", 5'd15, 32'h0000_4C38);
        rd("unmapped", 5'd3, 32'd0);

        // Plain exception.
        exc_get = 1'b1; exc_code = 5'd12; pc_m = 32'h3010; bd_m = 1'b0;
        tick();
        exc_get = 1'b0;
        chk("exc_flush1", 32'(flush), 32'd1);
        chk("exc_busy", 32'(busy), 32'd1);
        chk("exc_rv0", 32'(redir_valid), 32'd0);
        chk("exc_epc", epc, 32'h3010);
        rd("exc_cause", 5'd13, 32'h0000_0030);
        rd("exc_sr", 5'd12, 32'h0000_0002);
        tick();
        chk("exc_flush2", 32'(flush), 32'd1);
        tick();
        chk("exc_flush3", 32'(flush), 32'd0);
        chk("exc_rv", 32'(redir_valid), 32'd1);
        chk("exc_rpc", redir_pc, 32'h0000_4180);
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("exc_idle", 32'(busy), 32'd0);
        chk("exc_rv_off", 32'(redir_valid), 32'd0);

        // Delay-slot exception.
        exc_get = 1'b1; exc_code = 5'd4; pc_m = 32'h3024; bd_m = 1'b1;
        tick();
        exc_get = 1'b0; bd_m = 1'b0;
        chk("bd_epc", epc, 32'h3020);
        rd("bd_cause", 5'd13, 32'h8000_0010);
        finish_seq("bd");

        // Interrupt beats a same-cycle exception.
        mtc0(5'd12, 32'h0000_0401);
        rd("int_sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_get = 1'b1; exc_code = 5'd12; pc_m = 32'h3200;
        tick();
        hw_int = '0; exc_get = 1'b0;
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        chk("int_epc", epc, 32'h3200);
        chk("int_flush", 32'(flush), 32'd1);
        finish_seq("int");

        // ERET with a stalled redirect handshake; mtc0 while busy is dropped.
        mtc0(5'd14, 32'h3100);
        chk("eret_epc_wr", epc, 32'h3100);
        eret_m = 1'b1;
        tick();
        eret_m = 1'b0;
        chk("eret_flush", 32'(flush), 32'd1);
        rd("eret_sr", 5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'hDEAD_0000);
        chk("busy_mtc0", epc, 32'h3100);
        tick();
        chk("eret_rv", 32'(redir_valid), 32'd1);
        chk("eret_rpc", redir_pc, 32'h3100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("eret_hold_rv", 32'(redir_valid), 32'd1);
            chk("eret_hold_rpc", redir_pc, 32'h3100);
            chk("eret_hold_fl", 32'(flush), 32'd0);
        end
        redir_ready = 1'b1;
        tick();
        redir_ready = 1'b0;
        chk("eret_idle", 32'(busy), 32'd0);
        chk("eret_rv_off", 32'(redir_valid), 32'd0);

        // Masking by EXL, then by IE=0.
        mtc0(5'd12, 32'h0000_0403);
        hw_int = 6'b000001;
        tick();
        tick();
        chk("mask_exl_busy", 32'(busy), 32'd0);
        chk("mask_exl_fl", 32'(flush), 32'd0);
        mtc0(5'd12, 32'h0000_0400);
        tick();
        tick();
        chk("mask_ie_busy", 32'(busy), 32'd0);
        chk("mask_ie_fl", 32'(flush), 32'd0);
        rd("mask_cause", 5'd13, 32'h0000_0400);
        rd("mask_prid", 5'd15, 32'h0000_4C38);
        hw_int = '0;

        // Reset in the middle of a flush.
        exc_get = 1'b1; exc_code = 5'd12; pc_m = 32'h5000;
        tick();
        exc_get = 1'b0;
        chk("rmid_flush", 32'(flush), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmid_flush0", 32'(flush), 32'd0);
        chk("rmid_busy0", 32'(busy), 32'd0);
        chk("rmid_epc", epc, 32'd0);
        rd("rmid_sr", 5'd12, 32'd0);
        rd("rmid_cause", 5'd13, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rmid_no_rv", 32'(redir_valid), 32'd0);
            chk("rmid_no_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: exc_get  in  1  M-stage instruction carries an exception; exc_code  in  5  its code.
REQ-004 SHALL have ports: pc_m  in  32  M-stage PC; bd_m  in  1  M-stage instruction is in a branch delay slot.
REQ-005 SHALL have ports: hw_int  in  6  external interrupt lines, level-sensitive.
REQ-006 SHALL have ports: eret_m  in  1  ERET in M stage.
REQ-007 SHALL have ports: mtc0_we  in  1  CP0 write enable; c0_addr  in  5  CP0 register select; mtc0_wdata  in  32  write data.
REQ-008 SHALL have ports: mfc0_rdata  out  32  combinational read of the register selected by c0_addr.
REQ-009 SHALL have ports: flush  out  1  kill F/D/E/M stages; busy  out  1  FSM not IDLE.
REQ-010 SHALL have ports: redir_valid  out  1  redirect request; redir_pc  out  32  target; redir_ready  in  1  fetch accepts the redirect.
REQ-011 SHALL have ports: epc  out  32  current EPC value.

Function
REQ-012 SHALL implement SR (addr 12): IM[15:10], EXL[1], IE[0]; other bits read 0.
REQ-013 SHALL implement Cause (addr 13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; Cause is read-only to mtc0.
REQ-014 SHALL implement EPC (addr 14), read/write, and PRId (addr 15) constant 32'h0000_4C38; other addresses read 0.
REQ-015 SHALL load Cause.IP from hw_int every clock cycle, independent of FSM state.
REQ-016 SHALL compute int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
REQ-017 SHALL use FSM states IDLE, FLUSH, REDIRECT.
REQ-018 SHALL, in IDLE, take an event with priority int_req > exc_get > eret_m; lower-priority events in the same cycle are dropped.
REQ-019 SHALL, on taking an interrupt or exception: EXL<=1, Cause.BD<=bd_m, Cause.ExcCode<=0 (interrupt) or exc_code, EPC<={(bd_m ? pc_m-4 : pc_m)[31:2],2'b00}, target<=32'h0000_4180.
REQ-020 SHALL, on taking ERET: EXL<=0, target<=EPC (value before any same-cycle mtc0).
REQ-021 SHALL, on any taken event, enter FLUSH with a 2-bit counter set to 1; flush SHALL be high in FLUSH for exactly 2 cycles, then enter REDIRECT.
REQ-022 SHALL hold redir_valid=1 and redir_pc=target stable in REDIRECT until a cycle with redir_ready=1, then return to IDLE the next cycle.
REQ-023 SHALL ignore exc_get, eret_m and int_req while busy=1 (the pipeline is being flushed).
REQ-024 SHALL apply mtc0 writes to SR/EPC at the clock edge when mtc0_we=1, except a same-cycle taken event overrides the fields it writes (EXL, EPC).
REQ-025 SHALL ignore mtc0_we while busy=1.
REQ-026 SHALL keep flush and redir_valid mutually exclusive and both 0 in IDLE.

Reset
REQ-027 SHALL on reset set state=IDLE, SR=0, Cause=0, EPC=0, target=0, counter=0, flush=0, redir_valid=0, busy=0.
REQ-028 SHALL, on reset asserted mid-FLUSH or mid-REDIRECT, abandon the sequence; no redirect is issued after reset release.

Verification
REQ-029 Exception: IDLE, exc_get=1, exc_code=5'd12, pc_m=32'h3010, bd_m=0 -> 2 cycles flush=1, then redir_valid=1, redir_pc=32'h4180; EPC=32'h3010, Cause=32'h0000_0030, SR.EXL=1.
REQ-030 Delay slot: exc_get=1, pc_m=32'h3024, bd_m=1 -> EPC=32'h3020, Cause[31]=1.
REQ-031 Interrupt priority: SR=32'h0000_0401, hw_int=6'b000001, exc_get=1 same cycle -> Cause.ExcCode=0, Cause.IP=6'b000001; exc_code discarded.
REQ-032 ERET + handshake: EPC=32'h3100, EXL=1, eret_m=1 -> EXL=0, redir_pc=32'h3100 held with redir_ready=0 for 3 cycles, IDLE one cycle after redir_ready=1.
REQ-033 Masking: SR.EXL=1 or SR.IE=0 with hw_int active -> no flush, state stays IDLE; mfc0 of addr 15 -> 32'h0000_4C38.
REQ-034 Reset mid-FLUSH: reset for 1 cycle during FLUSH -> flush=0 immediately, SR=Cause=EPC=0, no redir_valid after release.
